// File: rtl/lfsr_ctrl_pkg.sv
// Shared types for the LFSR sharing controller: FSM encoding and counter sizing.
package lfsr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_WARM  = 2'd1,
    ST_READY = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Counter must hold max(WARMUP, STRIDE)-1; never narrower than one bit.
  function automatic int cnt_width(input int warmup, input int stride);
    int m;
    m = (warmup > stride) ? warmup : stride;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/dffr.sv
// Plain resettable register with asynchronous active-low reset.
module dffr #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_o <= RST;
    else          q_o <= d_i;
  end

endmodule

// File: rtl/lfsr_galois.sv
// Free-running right-shift Galois LFSR; a write overrides the step for one cycle.
module lfsr_galois #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY       = 32'h8020_0003
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] state_o
);

  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    if (wr_i)           lfsr_d = dat_i;
    else if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ POLY;
    else                lfsr_d = lfsr_q >> 1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= '0;
    else          lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      win_o,
  output logic               vld_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    vld_o = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (en_i && !vld_o && req_i[idx]) begin
        vld_o      = 1'b1;
        win_o      = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Seeds, warms up and time-shares one free-running Galois LFSR among NUM_REQ requesters.
module lfsr_share_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY       = 32'h8020_0003,
  parameter logic [DATA_WIDTH-1:0] SEED_DEF   = 32'h0000_0001,
  parameter int                    NUM_REQ    = 4,
  parameter int                    WARMUP     = 16,
  parameter int                    STRIDE     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  seed_wr_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic [NUM_REQ-1:0]    req_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [DATA_WIDTH-1:0] rnd_o,
  output logic                  ready_o,
  output logic                  lockup_o
);

  localparam int            IW      = $clog2(NUM_REQ);
  localparam int            CW      = cnt_width(WARMUP, STRIDE);
  localparam logic [CW-1:0] WARM_LD = CW'(WARMUP - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(STRIDE - 1);

  logic [1:0]            state_raw;
  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, arb_gnt;
  logic [DATA_WIDTH-1:0] rnd_q, lfsr_st, lfsr_dat;
  logic [IW-1:0]         arb_win;
  logic                  arb_vld, arb_en, lock_det, lfsr_wr;
  logic                  ready_q, lockup_q;

  dffr #(.W(2), .RST(ST_INIT)) u_state (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(state_d), .q_o(state_raw)
  );
  assign state_q = state_t'(state_raw);

  dffr #(.W(IW), .RST('0)) u_ptr (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(ptr_d), .q_o(ptr_q)
  );

  lfsr_galois #(.DATA_WIDTH(DATA_WIDTH), .POLY(POLY)) u_lfsr (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_i(lfsr_wr), .dat_i(lfsr_dat), .state_o(lfsr_st)
  );

  // A seed write or lock-up recovery in the same cycle discards any selection.
  assign lock_det = (state_q != ST_INIT) && (lfsr_st == '0);
  assign arb_en   = (state_q == ST_READY) && !seed_wr_i && !lock_det;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i(req_i), .ptr_i(ptr_q), .en_i(arb_en),
    .gnt_o(arb_gnt), .win_o(arb_win), .vld_o(arb_vld)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    lfsr_wr  = 1'b0;
    lfsr_dat = SEED_DEF;
    if (seed_wr_i || lock_det) begin
      lfsr_wr = 1'b1;
      if (seed_wr_i && seed_i != '0) lfsr_dat = seed_i;
      state_d = ST_WARM;
      cnt_d   = WARM_LD;
    end else begin
      case (state_q)
        ST_INIT: begin
          lfsr_wr = 1'b1;
          state_d = ST_WARM;
          cnt_d   = WARM_LD;
        end
        ST_WARM, ST_GAP: begin
          if (cnt_q == '0) state_d = ST_READY;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_READY: begin
          if (arb_vld) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
            ptr_d   = (arb_win == IW'(NUM_REQ - 1)) ? '0 : arb_win + 1'b1;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      gnt_q    <= '0;
      rnd_q    <= '0;
      ready_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      gnt_q   <= arb_gnt;
      ready_q <= (state_d == ST_READY);
      if (arb_vld)  rnd_q    <= lfsr_st;
      if (lock_det) lockup_q <= 1'b1;
    end
  end

  assign gnt_o    = gnt_q;
  assign rnd_o    = rnd_q;
  assign ready_o  = ready_q;
  assign lockup_o = lockup_q;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Scoreboard bench: stimulus queues expected grants, a negedge monitor pops and compares.
module tb_lfsr_share_ctrl;

  localparam logic [7:0] POLY = 8'hB8;
  localparam logic [7:0] SDEF = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seed_wr = 1'b0;
  logic [7:0] seed = '0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [7:0] rnd;
  logic       ready, lockup;

  always #5 clk = ~clk;

  lfsr_share_ctrl #(
    .DATA_WIDTH(8), .POLY(POLY), .SEED_DEF(SDEF),
    .NUM_REQ(4), .WARMUP(1), .STRIDE(8)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .seed_wr_i(seed_wr), .seed_i(seed),
    .req_i(req), .gnt_o(gnt), .rnd_o(rnd), .ready_o(ready), .lockup_o(lockup)
  );

  typedef struct packed {
    logic [3:0]  gnt;
    logic [7:0]  rnd;
    logic [31:0] cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         base = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] mdl = '0;
  logic       ld = 1'b0;
  logic [7:0] ldv = '0;

  function automatic logic [7:0] step(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: loads when the bench expects a seed load, otherwise steps.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl <= '0;
    else        mdl <= ld ? ldv : step(mdl);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc - base);
  endtask

  task automatic goto(input int k);
    while (cyc - base < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_gnt(input logic [3:0] g);
    exp_t e;
    e.gnt = g;
    e.rnd = mdl;
    e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && gnt != '0) begin
      if (sb.size() == 0) chk("unexpected_gnt", {28'd0, gnt}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("gnt", {28'd0, gnt}, {28'd0, e.gnt});
        chk("rnd", {24'd0, rnd}, {24'd0, e.rnd});
        chk("gnt_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #12;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_rnd", {24'd0, rnd}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_lockup", {31'd0, lockup}, 32'd0);
    chk("rst_lfsr", {24'd0, dut.u_lfsr.lfsr_q}, 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = cyc;
    ld    = 1'b1;
    ldv   = SDEF;

    goto(1);
    ld = 1'b0;
    chk("lfsr_after_init", {24'd0, dut.u_lfsr.lfsr_q}, 32'h01);
    chk("ready_warm", {31'd0, ready}, 32'd0);

    goto(2);
    chk("lfsr_step1", {24'd0, dut.u_lfsr.lfsr_q}, 32'hB8);
    chk("ready_up", {31'd0, ready}, 32'd1);
    req = 4'b1111;
    expect_gnt(4'b0001);
    goto(11); expect_gnt(4'b0010);
    goto(20); expect_gnt(4'b0100);
    goto(29); expect_gnt(4'b1000);
    goto(38); expect_gnt(4'b0001);

    // Pointer is 1 here; a lone request from 3 brings it back to 0.
    goto(39); req = 4'b1000;
    goto(47); expect_gnt(4'b1000);
    goto(48); req = 4'b0100;
    goto(56); expect_gnt(4'b0100);
    goto(57); req = 4'b0101;
    goto(65); expect_gnt(4'b0001);
    goto(66); req = 4'b0010;
    goto(74); expect_gnt(4'b0010);
    goto(75); req = 4'b0000;

    // Zero seed written during GAP falls back to the default seed.
    goto(77);
    seed_wr = 1'b1; seed = 8'h00; ld = 1'b1; ldv = SDEF;
    goto(78);
    seed_wr = 1'b0; ld = 1'b0; req = 4'b0010;
    chk("ready_after_seed0", {31'd0, ready}, 32'd0);
    goto(79);
    expect_gnt(4'b0010);
    chk("lockup_after_seed0", {31'd0, lockup}, 32'd0);
    goto(80); req = 4'b0000;

    // Seed write colliding with a request in READY.
    goto(88);
    seed_wr = 1'b1; seed = 8'h5A; req = 4'b0010; ld = 1'b1; ldv = 8'h5A;
    goto(89);
    seed_wr = 1'b0; ld = 1'b0;
    chk("ready_after_seed", {31'd0, ready}, 32'd0);
    goto(90); expect_gnt(4'b0010);
    goto(91); req = 4'b0000;

    // Lock-up recovery from a forced all-zero state.
    goto(100);
    ld = 1'b1; ldv = SDEF;
    force dut.u_lfsr.lfsr_q = '0;
    #7;
    release dut.u_lfsr.lfsr_q;
    goto(101);
    ld = 1'b0; req = 4'b0001;
    chk("lockup_set", {31'd0, lockup}, 32'd1);
    chk("ready_after_lockup", {31'd0, ready}, 32'd0);
    goto(102); expect_gnt(4'b0001);
    goto(103); req = 4'b0000;

    goto(115);
    chk("lockup_sticky", {31'd0, lockup}, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
